// File: rtl/shifter_pkg.sv
// Shared definitions for the execute-stage shifter: data width, op encodings
// and the fixed-amount shift/rotate primitive used by every pipeline stage.
package shifter_pkg;

  localparam int WIDTH  = 16;
  localparam int STAGES = $clog2(WIDTH);
  localparam int CNT_W  = STAGES;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Encodings match the ISA decoder and the ALU result mux.
  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  // Shift or rotate by a constant amount. The fill rule depends on the op:
  // rotates wrap the bits shifted out, SLL fills zeros, SRA replicates the
  // sign bit of this stage's input.
  function automatic word_t shift_fixed(input word_t d, input op_e op,
                                        input int amt);
    word_t r;
    case (op)
      OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
      OP_SLL:  r = d << amt;
      OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
      OP_SRA:  r = word_t'($signed(d) >>> amt);
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One elastic pipeline stage of the barrel shifter. Shifts the upstream
// operand by SHAMT when the matching count bit is set, then registers the
// result together with the count and op so later stages can continue.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int SHAMT = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  // upstream side
  input  logic  up_valid,
  output logic  up_ready,
  input  word_t up_data,
  input  cnt_t  up_cnt,
  input  op_e   up_op,
  // downstream side
  input  logic  down_ready,
  output logic  valid,
  output word_t data,
  output cnt_t  cnt,
  output op_e   op
);

  // Count bit that enables this stage: SHAMT is a power of two.
  localparam int BIT = $clog2(SHAMT);

  word_t shifted;

  // The register may load when empty, when its content leaves this cycle, or
  // when a flush empties it anyway (flush keeps the input side ready).
  assign up_ready = flush || !valid || down_ready;

  // Apply this stage's power-of-two shift, or pass the operand through.
  // NOTE: combinational blocks assign every output on every path so no latch is inferred.
  always_comb begin
    shifted = up_data;
    if (up_cnt[BIT]) begin
      shifted = shift_fixed(up_data, up_op, SHAMT);
    end
  end

  // Stage register: flush empties it, otherwise it loads when allowed to.
  // NOTE: sequential state uses non-blocking assignments so all stages update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload is reset too, so out_data reads zero during and after reset.
      valid <= 1'b0;
      data  <= '0;
      cnt   <= '0;
      op    <= OP_ROL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= up_valid;
      // Payload only moves on a real transfer, keeping held data stable.
      if (up_valid) begin
        data <= shifted;
        cnt  <= up_cnt;
        op   <= up_op;
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Four-stage registered barrel shifter (ROL/SLL/ROR/SRA on 16 bits) with a
// valid/ready handshake on both sides. Stage k shifts by 2^k; the last stage
// register is the output register. One result per cycle, four entries deep,
// results leave in acceptance order.
module shift_pipe
  import shifter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Per-stage upstream inputs and registered outputs.
  logic  up_vld [STAGES];
  word_t up_dat [STAGES];
  cnt_t  up_cnt [STAGES];
  op_e   up_op  [STAGES];
  logic  dn_rdy [STAGES];

  logic  vld    [STAGES];
  logic  rdy    [STAGES];
  word_t dat    [STAGES];
  cnt_t  cnt_q  [STAGES];
  op_e   op_q   [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    // Stage 0 takes the operand straight from the input port.
    if (g == 0) begin : g_head
      assign up_vld[g] = in_valid;
      assign up_dat[g] = in_data;
      assign up_cnt[g] = in_cnt;
      assign up_op[g]  = op_e'(in_op);
    end else begin : g_body
      assign up_vld[g] = vld[g-1];
      assign up_dat[g] = dat[g-1];
      assign up_cnt[g] = cnt_q[g-1];
      assign up_op[g]  = op_q[g-1];
    end

    // The last stage is the output register, drained by the consumer.
    if (g == STAGES - 1) begin : g_tail
      assign dn_rdy[g] = out_ready;
    end else begin : g_mid
      assign dn_rdy[g] = rdy[g+1];
    end

    shift_stage #(
      .SHAMT (1 << g)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .up_valid   (up_vld[g]),
      .up_ready   (rdy[g]),
      .up_data    (up_dat[g]),
      .up_cnt     (up_cnt[g]),
      .up_op      (up_op[g]),
      .down_ready (dn_rdy[g]),
      .valid      (vld[g]),
      .data       (dat[g]),
      .cnt        (cnt_q[g]),
      .op         (op_q[g])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign out_data  = dat[STAGES-1];

  // The output register still carries count and op; nothing downstream needs them.
  logic unused_tail;
  assign unused_tail = ^{cnt_q[STAGES-1], op_q[STAGES-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases with literal results,
// streaming, backpressure, flush, async reset and a randomized run, all
// cross-checked every cycle against an in-order queue model.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;

  shift_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result from the op definitions over the full count at once.
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] d, input int n);
    logic [31:0] dd;
    int s;
    dd = {d, d};
    case (op)
      2'd0: begin dd = dd << n; return dd[31:16]; end
      2'd1: return d << n;
      2'd2: begin dd = dd >> n; return dd[15:0]; end
      default: begin s = $signed(d); s = s >>> n; return s[15:0]; end
    endcase
  endfunction

  // Model: in-order queue of accepted entries with their accept edge number.
  // The oldest entry is never blocked before the output register, so it is
  // visible exactly when three edges have passed since its accept edge.
  typedef struct {
    int          stamp;
    logic [15:0] res;
  } ent_t;

  ent_t q[$];
  int   m     = 0;
  int   n_out = 0;

  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    ent_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_valid = (q.size() > 0) && (m - q[0].stamp >= 3);
      exp_ready = flush || (q.size() < 4) || (out_ready && exp_valid);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      if (exp_valid) check("out_data", 32'(out_data), 32'(q[0].res));
      if (out_valid && out_ready) n_out++;
      if (flush) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          e.stamp = m + 1;
          e.res   = ref_shift(in_op, in_data, int'(in_cnt));
          q.push_back(e);
        end
      end
    end
    m++;
  end

  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  // Single operation into an empty pipe; checks latency and a literal result.
  task automatic run_one(input string name, input logic [1:0] op, input logic [15:0] d,
                         input logic [3:0] c, input logic [15:0] exp);
    int lat;
    in_valid = 1'b1; in_op = op; in_data = d; in_cnt = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'd3);
    check(name, 32'(out_data), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic drive_bp(input int i);
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_data  = 16'(16'h1111 * (i + 1));
    in_cnt   = 4'(i + 1);
  endtask

  initial begin
    logic [15:0] vals[$];
    logic [15:0] hold;
    int          first, last, idx, base, guard;
    bit          acc, have;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_cnt = '0; in_op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed ops with hand-computed results.
    run_one("sll_15", 2'd1, 16'h0001, 4'd15, 16'h8000);
    run_one("rol_1",  2'd0, 16'h8001, 4'd1,  16'h0003);
    run_one("ror_4",  2'd2, 16'h0001, 4'd4,  16'h1000);
    run_one("sra_neg", 2'd3, 16'h8000, 4'd4, 16'hF800);
    run_one("sra_pos", 2'd3, 16'h7000, 4'd4, 16'h0700);
    run_one("ror_13", 2'd2, 16'h0001, 4'd13, 16'h0008);
    for (int op = 0; op < 4; op++) run_one("cnt0", 2'(op), 16'hA5C3, 4'd0, 16'hA5C3);

    // Streaming: 16 back-to-back SLLs must emerge without bubbles.
    first = -1; last = -1;
    for (int i = 0; i < 24; i++) begin
      if (i < 16) begin
        in_valid = 1'b1; in_op = 2'd1; in_data = 16'h0001; in_cnt = 4'(i);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        vals.push_back(out_data);
        if (first < 0) first = i;
        last = i;
      end
      @(posedge clk); #1;
    end
    check("stream_count", 32'(vals.size()), 32'd16);
    check("stream_span", 32'(last - first), 32'd15);
    for (int k = 0; k < vals.size(); k++) check("stream_val", 32'(vals[k]), 32'(16'd1 << k));

    // Backpressure: six ops offered while the consumer stalls for five cycles.
    out_ready = 1'b0; idx = 0; have = 1'b0; hold = '0;
    drive_bp(0);
    for (int c = 0; c < 5; c++) begin
      step(acc);
      if (acc) idx++;
      if (idx < 6) drive_bp(idx); else in_valid = 1'b0;
      if (out_valid && !have) begin hold = out_data; have = 1'b1; end
    end
    check("bp_accepts", 32'(idx), 32'd4);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_hold", 32'(out_data), 32'(hold));
    base = n_out;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    guard = 0;
    while ((idx < 6 || n_out - base < 6) && guard < 30) begin
      step(acc);
      if (acc) idx++;
      if (idx < 6) drive_bp(idx); else in_valid = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", 32'(n_out - base), 32'd6);

    // Flush: three entries in flight, flush together with a new offer.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'd1; in_data = 16'(i + 5); in_cnt = 4'd3;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h1234; in_cnt = 4'd0;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    base = n_out;
    repeat (6) @(posedge clk);
    #1;
    check("fl_no_stale", 32'(n_out - base), 32'd0);

    // Async reset mid-stream, dropped between clock edges.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 2'd1; in_data = 16'h00F0; in_cnt = 4'd1;
      @(posedge clk); #1;
    end
    check("ar_pre_data", 32'(out_data), 32'h01E0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data", 32'(out_data), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("ar_in_ready", 32'(in_ready), 32'd1);
    run_one("ar_sll", 2'd1, 16'h0003, 4'd2, 16'h000C);

    // Randomized traffic with stalls and occasional flushes.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 16'($urandom);
      in_cnt    = 4'($urandom_range(15));
      in_op     = 2'($urandom_range(3));
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(49) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rand_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Four-stage registered barrel shifter for the execute stage. It applies the ISA shift/rotate ops (ROL, SLL, ROR, SRA) to a 16-bit operand, one power-of-two shift amount per stage. It sits between operand-forwarding logic and the ALU result mux. A valid/ready handshake on both sides gives one result per cycle and absorbs writeback stalls without losing data.

## Interface
- `WIDTH`, 16: data width. Fixed at 16; stage count is log2(WIDTH) = 4.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `flush` input 1: synchronous kill of all in-flight entries.
- `in_valid` input 1: upstream presents an operation.
- `in_ready` output 1: stage 1 can accept this cycle.
- `in_data` input 16: operand.
- `in_cnt` input 4: shift amount, 0..15.
- `in_op` input 2: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
- `out_valid` output 1: `out_data` holds a completed result.
- `out_ready` input 1: downstream consumes this cycle.
- `out_data` output 16: shift/rotate result.

## Operation
- Stage k (k = 0..3) shifts by 2^k when `cnt[k]` = 1; otherwise it passes data through.
- Each stage register carries `valid`, `data`, `cnt`, `op`.
- Stage 0's shift is applied combinationally to `in_data` before the stage-1 register. Stage 3 feeds the output register.
- Per-op fill at each stage:
  - SLL: fill with zeros.
  - SRA: fill with `data[15]` of that stage's input.
  - ROL/ROR: wrap the bits shifted out back in.
- Cascaded stages give the exact total: e.g. ROR by 13 = 1 + 4 + 8.
- `cnt` = 0 passes the operand through unchanged for every op.
- Elastic pipeline:
  - Stage i advances when it is empty or stage i+1 advances.
  - The output stage advances when `!out_valid || out_ready`.
  - `in_ready` = stage 1 empty or stage 1 advancing. It depends combinationally on `out_ready` through the chain.
- Transfers occur only on `valid && ready` at a clock edge.
- Capacity is 4 entries. Results leave in acceptance order.
- While `out_valid && !out_ready`, `out_data` is held stable.
- `flush`:
  - Clears every stage valid at the next edge, including the output.
  - Any input offered that same cycle is dropped; `in_ready` is still 1.
  - `flush` has priority over simultaneous accept and consume.
- Reset (`rst_n` low):
  - Immediately, asynchronously, clears all valids and zeros `data`, `cnt`, `op`.
  - `out_valid` = 0, `out_data` = 0, `in_ready` = 1 once `rst_n` is high.
  - Reset mid-operation discards all in-flight entries; nothing is replayed.

## Timing
- Latency: an operand accepted at edge t appears with `out_valid` = 1 after edge t+3, i.e. 4 edges counting the accept edge, provided `out_ready` is held high.
- Throughput: 1 result per cycle under continuous `in_valid`/`out_ready`.
- Backpressure: with `out_ready` low, the pipeline fills in 4 cycles. `in_ready` then falls in the same cycle the fourth entry is in the output register and stage 1 is occupied.
- `in_ready` rises in the same cycle `out_ready` rises, because the chain advances together.
- The first edge after `rst_n` deasserts may accept an input.

## Structure
- Shared package `shifter_pkg` holds the op encodings (`OP_ROL`, `OP_SLL`, `OP_ROR`, `OP_SRA`) and `WIDTH`. The decoder and ALU share these.
- One sub-module, `shift_stage`, parameterized by `SHAMT` (1/2/4/8):
  - Combinational shift/rotate of its input by `SHAMT` when enabled.
  - Registered `valid/data/cnt/op` with the advance logic.
- The top level instantiates four `shift_stage` instances and wires the ready chain.

## Test plan
- Basic ops with `out_ready` = 1:
  - SLL `0x0001` cnt 15 → `0x8000`, 4 cycles after accept.
  - ROL `0x8001` cnt 1 → `0x0003`.
  - ROR `0x0001` cnt 4 → `0x1000`.
  - SRA `0x8000` cnt 4 → `0xF800`.
  - SRA `0x7000` cnt 4 → `0x0700`.
  - Any op with cnt 0 on `0xA5C3` → `0xA5C3`.
- Streaming: 16 back-to-back SLL of `0x0001` with cnt 0..15 → 16 consecutive `out_valid` cycles with `0x0001 << n`, in order, no bubbles.
- Backpressure:
  - Send 6 ops while `out_ready` = 0 for 5 cycles.
  - `in_ready` drops after 4 accepts and `out_data` stays stable.
  - After release, all 6 results emerge in order with none lost or duplicated.
- Flush: with 3 entries in flight, pulse `flush` together with `in_valid` → next cycle all valids are 0, the offered input is dropped, and no stale output appears.
- Async reset: drop `rst_n` mid-stream between edges → `out_valid` = 0 and `out_data` = `0x0000` immediately. After release `in_ready` = 1 and a new SLL `0x0003` cnt 2 yields `0x000C`.
